// File: rtl/icache_stage1.sv
// ============================================================================
// Module   : icache_stage1
// Brief    : I-cache front stage. Indexes the tag/valid/data arrays, registers
//            requests for stage 2, and performs refill writes and set replays.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_stage1_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } s1_s2_stage_reg_t;
endpackage

module icache_stage1
    import icache_stage1_pkg::*;
#(
    parameter int NUM_WAYS  = 4,
    parameter int SET_BITS  = 4,
    parameter int LINE_BITS = 256,
    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8),
    localparam int TAG_BITS    = 32 - OFFSET_BITS - SET_BITS,
    localparam int WAY_BITS    = $clog2(NUM_WAYS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             ufp_addr,
    input  logic [3:0]              ufp_rmask,
    input  logic [3:0]              ufp_wmask,
    input  logic [31:0]             ufp_wdata,
    output logic                    ufp_ready,
    input  logic                    stall_sig,
    input  logic [31:0]             old_ufp_addr,
    input  logic [WAY_BITS-1:0]     way_evict,
    input  logic                    dfp_read,
    input  logic                    dfp_resp,
    input  logic [LINE_BITS-1:0]    dfp_rdata,
    output s1_s2_stage_reg_t        s1_s2_reg,
    output logic                    arr_csb,
    output logic [NUM_WAYS-1:0]     arr_web,
    output logic [SET_BITS-1:0]     arr_set,
    output logic [LINE_BITS-1:0]    arr_wdata,
    output logic [TAG_BITS:0]       arr_wtag,
    output logic                    arr_wvalid,
    output logic [31:0]             sram_addr [NUM_WAYS]
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_REPLAY = 2'd2;

    logic [1:0]             state_q, state_d;
    s1_s2_stage_reg_t       s1_s2_q, s1_s2_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic [WAY_BITS-1:0]    way_q, way_d;
    logic [31:0]            sram_addr_q [NUM_WAYS];
    logic [31:0]            sram_addr_d [NUM_WAYS];

    logic [SET_BITS-1:0]    old_set;
    logic [SET_BITS-1:0]    new_set;
    logic [31:0]            refill_line_addr;
    logic                   unused_old_offset;

    assign old_set           = old_ufp_addr[OFFSET_BITS +: SET_BITS];
    assign new_set           = ufp_addr[OFFSET_BITS +: SET_BITS];
    assign refill_line_addr  = {old_ufp_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign unused_old_offset = ^old_ufp_addr[OFFSET_BITS-1:0];

    assign s1_s2_reg  = s1_s2_q;
    assign arr_wdata  = line_q;
    assign arr_wtag   = {1'b0, old_ufp_addr[31 -: TAG_BITS]};

    always_comb begin
        state_d    = state_q;
        s1_s2_d    = s1_s2_q;
        line_d     = line_q;
        way_d      = way_q;
        ufp_ready  = 1'b0;
        arr_csb    = 1'b1;
        arr_web    = '1;
        arr_set    = old_set;
        arr_wvalid = 1'b0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            sram_addr_d[i] = sram_addr_q[i];
        end

        case (state_q)
            ST_RUN: begin
                arr_csb = 1'b0;
                if (!stall_sig) begin
                    ufp_ready     = 1'b1;
                    arr_set       = new_set;
                    s1_s2_d.addr  = ufp_addr;
                    s1_s2_d.rmask = ufp_rmask;
                    s1_s2_d.wmask = ufp_wmask;
                    s1_s2_d.wdata = ufp_wdata;
                end else if (dfp_read && dfp_resp) begin
                    state_d = ST_REFILL;
                    line_d  = dfp_rdata;
                    way_d   = way_evict;
                end
            end
            ST_REFILL: begin
                arr_csb    = 1'b0;
                arr_wvalid = 1'b1;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    arr_web[w] = (way_q != WAY_BITS'(w));
                end
                sram_addr_d[way_q] = refill_line_addr;
                state_d = ST_REPLAY;
            end
            ST_REPLAY: begin
                // Re-read the refilled set so stage 2 resolves the miss as a hit.
                arr_csb = 1'b0;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // Array strobes must be inactive the instant reset is asserted.
        if (!rst) begin
            ufp_ready  = 1'b0;
            arr_csb    = 1'b1;
            arr_web    = '1;
            arr_wvalid = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_WAYS; i++) begin
            sram_addr[i] = sram_addr_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            s1_s2_q <= '0;
            line_q  <= '0;
            way_q   <= '0;
            for (int i = 0; i < NUM_WAYS; i++) begin
                sram_addr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            s1_s2_q <= s1_s2_d;
            line_q  <= line_d;
            way_q   <= way_d;
            for (int i = 0; i < NUM_WAYS; i++) begin
                sram_addr_q[i] <= sram_addr_d[i];
            end
        end
    end

endmodule

`default_nettype wire
